// File: rtl/alu_pkg.sv
// Shared constants for the ALU execution stage: operation codes, ALUOp and
// funct field encodings, and the FSM state encoding.
package alu_pkg;

   // Decoded 4-bit ALU operation codes (also exported for trace).
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001,
      ALU_MUL  = 4'b1010
   } alu_op_e;

   // ALUOp field from the main control unit.
   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   // funct7 encodings.
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // funct3 encodings.
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // Execution FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier returning the low XLEN bits of a*b.
// A start pulse loads the operands; XLEN steps follow, one per cycle.
// 'done' is high during the final step and 'product' is the accumulator
// value that step produces, so the caller can register it on that edge.
module alu_mul_iter #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

   logic             running_q, running_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  mcand_q, mcand_d;
   logic [XLEN-1:0]  mplier_q, mplier_d;
   logic [XLEN-1:0]  acc_q, acc_d;
   logic [XLEN-1:0]  step_sum;

   assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign done     = running_q && (cnt_q == LAST_STEP);
   assign product  = step_sum;

   // Load on start, otherwise perform one shift-add step while running.
   always_comb begin
      running_d = running_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      if (start) begin
         running_d = 1'b1;
         cnt_d     = '0;
         mcand_d   = a;
         mplier_d  = b;
         acc_d     = '0;
      end else if (running_q) begin
         acc_d    = step_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (cnt_q == LAST_STEP) begin
            running_d = 1'b0;
         end
      end
   end

   // Control flops: reset kills any multiply in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         running_q <= running_d;
         cnt_q     <= cnt_d;
      end
   end

   // Datapath flops: always reloaded by start before they are observed.
   // NOTE: these are deliberately not reset; running_q qualifies them, so a
   // reset here would only add fan-out on the reset net.
   always_ff @(posedge clk) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution stage: ALU-control decode plus datapath ALU with
// a registered result. Optional iterative MUL is enabled by the RV_MUL_EN
// macro; without it the MUL encoding decodes as illegal.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal,
   output logic [3:0]      alu_operation
);

   alu_state_e      state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic            illegal_q, illegal_d;
   alu_op_e         op_q, op_d;

   alu_op_e         dec_op;
   logic            dec_illegal;
   logic [XLEN-1:0] alu_res;
   logic [SHAMT_W-1:0] shamt;

`ifdef RV_MUL_EN
   logic            mul_start;
   logic            mul_done;
   logic [XLEN-1:0] mul_product;

   alu_mul_iter #(.XLEN(XLEN)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (op_a),
      .b       (op_b),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   assign shamt = op_b[SHAMT_W-1:0];

   // Decode ALUOp/funct7/funct3 into an operation code or an illegal flag.
   always_comb begin
      // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
      dec_op      = ALU_ADD;
      dec_illegal = 1'b0;
      case (ALUOp)
         ALUOP_MEM:    dec_op = ALU_ADD;
         ALUOP_BRANCH: dec_op = ALU_SUB;
         ALUOP_RTYPE: begin
            case ({Funct7, Funct3})
               {F7_BASE, F3_ADD_SUB}: dec_op = ALU_ADD;
               {F7_ALT,  F3_ADD_SUB}: dec_op = ALU_SUB;
               {F7_BASE, F3_AND}:     dec_op = ALU_AND;
               {F7_BASE, F3_OR}:      dec_op = ALU_OR;
               {F7_BASE, F3_XOR}:     dec_op = ALU_XOR;
               {F7_BASE, F3_SLL}:     dec_op = ALU_SLL;
               {F7_BASE, F3_SR}:      dec_op = ALU_SRL;
               {F7_ALT,  F3_SR}:      dec_op = ALU_SRA;
               {F7_BASE, F3_SLT}:     dec_op = ALU_SLT;
               {F7_BASE, F3_SLTU}:    dec_op = ALU_SLTU;
`ifdef RV_MUL_EN
               {F7_MULDIV, F3_ADD_SUB}: dec_op = ALU_MUL;
`endif
               default:               dec_illegal = 1'b1;
            endcase
         end
         ALUOP_ITYPE: begin
            case (Funct3)
               F3_ADD_SUB: dec_op = ALU_ADD;
               F3_AND:     dec_op = ALU_AND;
               F3_OR:      dec_op = ALU_OR;
               F3_XOR:     dec_op = ALU_XOR;
               F3_SLT:     dec_op = ALU_SLT;
               F3_SLTU:    dec_op = ALU_SLTU;
               F3_SLL:     dec_op = ALU_SLL;
               F3_SR:      dec_op = Funct7[5] ? ALU_SRA : ALU_SRL;
               default:    dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Single-cycle datapath; MUL is produced by the iterative unit instead.
   always_comb begin
      alu_res = '0;
      case (dec_op)
         ALU_ADD:  alu_res = op_a + op_b;
         ALU_SUB:  alu_res = op_a - op_b;
         ALU_AND:  alu_res = op_a & op_b;
         ALU_OR:   alu_res = op_a | op_b;
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_SLL:  alu_res = op_a << shamt;
         ALU_SRL:  alu_res = op_a >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default:  alu_res = '0;
      endcase
   end

   // Next-state and registered-output logic for IDLE/BUSY/DONE.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      op_d      = op_q;
`ifdef RV_MUL_EN
      mul_start = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d      = dec_op;
               illegal_d = dec_illegal;
`ifdef RV_MUL_EN
               if (!dec_illegal && dec_op == ALU_MUL) begin
                  mul_start = 1'b1;
                  state_d   = ST_BUSY;
               end else
`endif
               begin
                  result_d = dec_illegal ? '0 : alu_res;
                  zero_d   = dec_illegal || (alu_res == '0);
                  state_d  = ST_DONE;
               end
            end
         end
         ST_BUSY: begin
`ifdef RV_MUL_EN
            if (mul_done) begin
               result_d = mul_product;
               zero_d   = (mul_product == '0);
               state_d  = ST_DONE;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         op_q      <= ALU_AND;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
         op_q      <= op_d;
      end
   end

   assign in_ready      = (state_q == ST_IDLE);
   assign out_valid     = (state_q == ST_DONE);
   assign result        = result_q;
   assign zero          = zero_q;
   assign illegal       = illegal_q;
   assign alu_operation = op_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (XLEN=64): table of directed vectors
// plus hand-written sequences for backpressure, MUL latency and reset.
module tb_alu_exec_unit;

   localparam int XLEN = 64;

   logic            clk;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      ALUOp;
   logic [6:0]      Funct7;
   logic [2:0]      Funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;
   logic [3:0]      alu_operation;

   alu_exec_unit #(.XLEN(XLEN)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .ALUOp         (ALUOp),
      .Funct7        (Funct7),
      .Funct3        (Funct3),
      .op_a          (op_a),
      .op_b          (op_b),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result        (result),
      .zero          (zero),
      .illegal       (illegal),
      .alu_operation (alu_operation)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  aluop;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp_res;
      logic        exp_zero;
      logic        exp_ill;
      logic [3:0]  exp_op;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string nm, input logic [1:0] aluop, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] er, input logic ez, input logic ei,
                          input logic [3:0] eo);
      vec_t v;
      v.name = nm; v.aluop = aluop; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
      v.exp_res = er; v.exp_zero = ez; v.exp_ill = ei; v.exp_op = eo;
      vecs.push_back(v);
   endtask

   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   // Present a request, let it be accepted on the next edge, then scramble inputs.
   task automatic issue(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] b, input string nm);
      ALUOp = aluop; Funct7 = f7; Funct3 = f3; op_a = a; op_b = b;
      in_valid = 1'b1;
      check($sformatf("%s in_ready_before_accept", nm), in_ready, 1);
      wait_edge();
      in_valid = 1'b0;
      op_a   = ~op_a;
      op_b   = ~op_b;
      Funct3 = ~Funct3;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  lat;
      logic stale;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      ALUOp = 2'b00; Funct7 = '0; Funct3 = '0; op_a = '0; op_b = '0;

      //                name          ALUOp  F7         F3      op_a                   op_b                   result                 z     ill   op
      add_vec("sub_neg",   2'b10, 7'b0100000, 3'b000, 64'd5,                64'd7,                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'b0110);
      add_vec("sra_r",     2'b10, 7'b0100000, 3'b101, 64'h8000_0000_0000_0000, 64'h43,            64'hF000_0000_0000_0000, 1'b0, 1'b0, 4'b0111);
      add_vec("srl_r",     2'b10, 7'b0000000, 3'b101, 64'h8000_0000_0000_0000, 64'h43,            64'h1000_0000_0000_0000, 1'b0, 1'b0, 4'b0101);
      add_vec("ls_add",    2'b00, 7'b1111111, 3'b111, 64'd100,              64'hFFFF_FFFF_FFFF_FF9C, 64'd0,               1'b1, 1'b0, 4'b0010);
      add_vec("slt",       2'b10, 7'b0000000, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,             64'd1,                   1'b0, 1'b0, 4'b1000);
      add_vec("sltu",      2'b10, 7'b0000000, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,             64'd0,                   1'b1, 1'b0, 4'b1001);
      add_vec("and",       2'b10, 7'b0000000, 3'b111, 64'hF0F0,             64'hFF00,             64'hF000,                1'b0, 1'b0, 4'b0000);
      add_vec("or",        2'b10, 7'b0000000, 3'b110, 64'hF0F0,             64'h0F0F,             64'hFFFF,                1'b0, 1'b0, 4'b0001);
      add_vec("xor",       2'b10, 7'b0000000, 3'b100, 64'hFF,               64'h0F,               64'hF0,                  1'b0, 1'b0, 4'b0011);
      add_vec("sll_max",   2'b10, 7'b0000000, 3'b001, 64'd1,                64'h7F,               64'h8000_0000_0000_0000, 1'b0, 1'b0, 4'b0100);
      add_vec("add_wrap",  2'b10, 7'b0000000, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,             64'd0,                   1'b1, 1'b0, 4'b0010);
      add_vec("sub_under", 2'b10, 7'b0100000, 3'b000, 64'd0,                64'd1,                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'b0110);
      add_vec("srai",      2'b11, 7'b0100000, 3'b101, 64'hFFFF_FFFF_0000_0000, 64'd4,             64'hFFFF_FFFF_F000_0000, 1'b0, 1'b0, 4'b0111);
      add_vec("srli",      2'b11, 7'b0000000, 3'b101, 64'hFFFF_FFFF_0000_0000, 64'd4,             64'h0FFF_FFFF_F000_0000, 1'b0, 1'b0, 4'b0101);
      add_vec("addi",      2'b11, 7'b1010101, 3'b000, 64'd10,               64'hFFFF_FFFF_FFFF_FFFB, 64'd5,               1'b0, 1'b0, 4'b0010);
      add_vec("slti",      2'b11, 7'b0000000, 3'b010, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,           1'b0, 1'b0, 4'b1000);
      add_vec("ill_and",   2'b10, 7'b0100000, 3'b111, 64'd5,                64'd7,                64'd0,                   1'b1, 1'b1, 4'b0010);
      add_vec("ill_f7",    2'b10, 7'b1111111, 3'b000, 64'd5,                64'd7,                64'd0,                   1'b1, 1'b1, 4'b0010);
      add_vec("ill_mulh",  2'b10, 7'b0000001, 3'b001, 64'd5,                64'd7,                64'd0,                   1'b1, 1'b1, 4'b0010);

      // Reset state
      repeat (3) wait_edge();
      reset = 1'b0;
      check("rst in_ready", in_ready, 1);
      check("rst out_valid", out_valid, 0);
      check("rst result", result, 0);
      check("rst zero", zero, 0);
      check("rst illegal", illegal, 0);
      check("rst alu_operation", alu_operation, 4'b0000);

      // Table-driven single-cycle vectors
      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i].aluop, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].name);
         check($sformatf("%s out_valid", vecs[i].name), out_valid, 1);
         check($sformatf("%s result", vecs[i].name), result, vecs[i].exp_res);
         check($sformatf("%s zero", vecs[i].name), zero, vecs[i].exp_zero);
         check($sformatf("%s illegal", vecs[i].name), illegal, vecs[i].exp_ill);
         check($sformatf("%s alu_operation", vecs[i].name), alu_operation, vecs[i].exp_op);
         check($sformatf("%s in_ready_done", vecs[i].name), in_ready, 0);
         wait_edge();
         check($sformatf("%s out_valid_drop", vecs[i].name), out_valid, 0);
         check($sformatf("%s in_ready_back", vecs[i].name), in_ready, 1);
      end

      // Backpressure: hold result in DONE, new requests ignored
      out_ready = 1'b0;
      issue(2'b01, 7'b0, 3'b0, 64'h1234, 64'h1234, "bp");
      for (int k = 0; k < 4; k++) begin
         check($sformatf("bp%0d out_valid", k), out_valid, 1);
         check($sformatf("bp%0d result", k), result, 0);
         check($sformatf("bp%0d zero", k), zero, 1);
         check($sformatf("bp%0d alu_operation", k), alu_operation, 4'b0110);
         check($sformatf("bp%0d in_ready", k), in_ready, 0);
         ALUOp = 2'b00; op_a = 64'd1; op_b = 64'd1; in_valid = 1'b1;
         wait_edge();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_edge();
      check("bp release out_valid", out_valid, 0);
      check("bp release in_ready", in_ready, 1);
      wait_edge();
      check("bp ignored request", out_valid, 0);

      // MUL encoding: iterative when enabled, illegal otherwise
      issue(2'b10, 7'b0000001, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, "mul");
      lat = 1;
      while (!out_valid && lat < 200) begin
         if (lat == 10) check("mul busy in_ready", in_ready, 0);
         wait_edge();
         lat++;
      end
`ifdef RV_MUL_EN
      check("mul latency", lat, XLEN + 1);
      check("mul result", result, 64'hFFFF_FFFF_FFFF_FFFD);
      check("mul zero", zero, 0);
      check("mul illegal", illegal, 0);
      check("mul alu_operation", alu_operation, 4'b1010);
`else
      check("mul latency", lat, 1);
      check("mul result", result, 0);
      check("mul zero", zero, 1);
      check("mul illegal", illegal, 1);
      check("mul alu_operation", alu_operation, 4'b0010);
`endif
      wait_edge();
      check("mul out_valid_drop", out_valid, 0);

      // Reset discards a held result
      out_ready = 1'b0;
      issue(2'b00, 7'b0, 3'b0, 64'd2, 64'd3, "rsthold");
      check("rsthold result_before", result, 5);
      reset = 1'b1;
      repeat (3) wait_edge();
      reset = 1'b0;
      out_ready = 1'b1;
      check("rsthold in_ready", in_ready, 1);
      check("rsthold out_valid", out_valid, 0);
      check("rsthold result", result, 0);
      check("rsthold alu_operation", alu_operation, 4'b0000);

`ifdef RV_MUL_EN
      // Reset mid-MUL: no stale result may appear afterwards
      issue(2'b10, 7'b0000001, 3'b000, 64'd7, 64'd9, "rstmul");
      repeat (10) wait_edge();
      reset = 1'b1;
      repeat (3) wait_edge();
      reset = 1'b0;
      check("rstmul in_ready", in_ready, 1);
      check("rstmul out_valid", out_valid, 0);
      check("rstmul result", result, 0);
      stale = 1'b0;
      for (int c = 0; c < 80; c++) begin
         if (out_valid) stale = 1'b1;
         wait_edge();
      end
      check("rstmul stale output", stale, 0);
`endif

      // Unit still operational after reset
      issue(2'b00, 7'b0, 3'b0, 64'd1, 64'd1, "post");
      check("post out_valid", out_valid, 1);
      check("post result", result, 2);
      wait_edge();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
